result_uart_tx: RTL and testbench

- Serialises 32-bit ALU result words out of the core over a UART TX line for FPGA board validation.
- It is the output-side counterpart of the ALU operand-select path: operands go into the ALU, and this block carries results off-chip to a host terminal.
- It accepts one word per valid/ready handshake and sends it as 4 back-to-back 8N1 frames, least-significant byte first.

---
 rtl/result_uart_tx.sv | 183 ++++++++++++++++++
 tb/tb_result_uart_tx.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/result_uart_tx.sv
// Serialises 32-bit result words over a UART TX line, LSB byte first, 8N1 frames.
// Define RESULT_TX_PARITY_EN to insert an even-parity bit per byte (8E1 framing).
module result_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned NUM_BYTES    = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        res_valid,
  input  logic [31:0] res_data,
  output logic        res_ready,
  output logic        tx,
  output logic        busy,
  output logic        done
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned BYTE_W = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
  localparam int unsigned BIT_W  = 3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef RESULT_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t              r_state;
  state_t              w_state_n;
  logic [BAUD_W-1:0]   r_baud;
  logic [BAUD_W-1:0]   w_baud_n;
  logic [BIT_W-1:0]    r_bit;
  logic [BIT_W-1:0]    w_bit_n;
  logic [BYTE_W-1:0]   r_byte;
  logic [BYTE_W-1:0]   w_byte_n;
  logic [DATA_W-1:0]   r_shift;
  logic [DATA_W-1:0]   w_shift_n;
  logic                r_tx;
  logic                w_tx_n;
  logic                r_ready;
  logic                r_busy;
  logic                r_done;
  logic                w_done_n;
  logic                w_baud_end;
`ifdef RESULT_TX_PARITY_EN
  logic                r_parity;
  logic                w_parity_n;
`endif

  assign w_baud_end = (r_baud == BAUD_W'(CLKS_PER_BIT - 1));

  // State and datapath registers; tx idles high and is forced high by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_baud   <= '0;
      r_bit    <= '0;
      r_byte   <= '0;
      r_shift  <= '0;
      r_tx     <= 1'b1;
      r_ready  <= 1'b1;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
`ifdef RESULT_TX_PARITY_EN
      r_parity <= 1'b0;
`endif
    end else begin
      r_state  <= w_state_n;
      r_baud   <= w_baud_n;
      r_bit    <= w_bit_n;
      r_byte   <= w_byte_n;
      r_shift  <= w_shift_n;
      r_tx     <= w_tx_n;
      r_ready  <= (w_state_n == S_IDLE);
      r_busy   <= (w_state_n != S_IDLE);
      r_done   <= w_done_n;
`ifdef RESULT_TX_PARITY_EN
      r_parity <= w_parity_n;
`endif
    end
  end

  // Next-state logic; tx is derived from the next state so it changes with the state.
  always_comb begin
    w_state_n  = r_state;
    w_baud_n   = r_baud;
    w_bit_n    = r_bit;
    w_byte_n   = r_byte;
    w_shift_n  = r_shift;
    w_done_n   = 1'b0;
    w_tx_n     = 1'b1;
`ifdef RESULT_TX_PARITY_EN
    w_parity_n = r_parity;
`endif

    if (r_state != S_IDLE) begin
      w_baud_n = w_baud_end ? '0 : r_baud + BAUD_W'(1);
    end

    unique case (r_state)
      S_IDLE: begin
        if (res_valid && r_ready) begin
          w_state_n  = S_START;
          w_shift_n  = res_data;
          w_baud_n   = '0;
          w_bit_n    = '0;
          w_byte_n   = '0;
`ifdef RESULT_TX_PARITY_EN
          w_parity_n = 1'b0;
`endif
        end
      end
      S_START: begin
        if (w_baud_end) begin
          w_state_n = S_DATA;
          w_bit_n   = '0;
        end
      end
      S_DATA: begin
        if (w_baud_end) begin
          w_shift_n  = {1'b0, r_shift[DATA_W-1:1]};
`ifdef RESULT_TX_PARITY_EN
          w_parity_n = r_parity ^ r_shift[0];
`endif
          if (r_bit == BIT_W'(7)) begin
`ifdef RESULT_TX_PARITY_EN
            w_state_n = S_PARITY;
`else
            w_state_n = S_STOP;
`endif
          end else begin
            w_bit_n = r_bit + BIT_W'(1);
          end
        end
      end
`ifdef RESULT_TX_PARITY_EN
      S_PARITY: begin
        if (w_baud_end) begin
          w_state_n = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (w_baud_end) begin
          if (r_byte == BYTE_W'(NUM_BYTES - 1)) begin
            w_state_n = S_IDLE;
            w_byte_n  = '0;
            w_done_n  = 1'b1;
          end else begin
            w_state_n  = S_START;
            w_byte_n   = r_byte + BYTE_W'(1);
            w_bit_n    = '0;
`ifdef RESULT_TX_PARITY_EN
            w_parity_n = 1'b0;
`endif
          end
        end
      end
      default: begin
        w_state_n = S_IDLE;
      end
    endcase

    unique case (w_state_n)
      S_START:  w_tx_n = 1'b0;
      S_DATA:   w_tx_n = w_shift_n[0];
`ifdef RESULT_TX_PARITY_EN
      S_PARITY: w_tx_n = w_parity_n;
`endif
      default:  w_tx_n = 1'b1;
    endcase
  end

  assign tx        = r_tx;
  assign res_ready = r_ready;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule

// File: tb/tb_result_uart_tx.sv
// Self-checking bench for result_uart_tx: waveform-level model plus directed literal checks.
// Build with RESULT_TX_PARITY_EN defined to exercise the 8E1 variant.
`timescale 1ns/1ps
module tb_result_uart_tx;

  localparam int CPB = 4;
`ifdef RESULT_TX_PARITY_EN
  localparam int FB       = 11;
  localparam int DONE_LAT = 177;
`else
  localparam int FB       = 10;
  localparam int DONE_LAT = 161;
`endif
  localparam int WORD_CYC = 4 * FB * CPB;
  localparam int MAXC     = 8192;
  localparam logic [3:0] IDLE_OBS = 4'b1100;  // {tx, res_ready, busy, done}

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        res_valid = 1'b0;
  logic [31:0] res_data = 32'h0;
  logic        res_ready;
  logic        tx;
  logic        busy;
  logic        done;

  result_uart_tx #(.CLKS_PER_BIT(CPB), .NUM_BYTES(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .res_valid (res_valid),
    .res_data  (res_data),
    .res_ready (res_ready),
    .tx        (tx),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  // Model: every accepted word expands into its per-cycle line waveform.
  logic [3:0] exp_q[$];
  logic [3:0] exp_now = IDLE_OBS;

  task automatic push_n(input logic [3:0] v);
    for (int i = 0; i < CPB; i++) exp_q.push_back(v);
  endtask

  task automatic push_word(input logic [31:0] w);
    for (int b = 0; b < 4; b++) begin
      push_n(4'b0010);
      for (int i = 0; i < 8; i++) push_n({w[8*b+i], 3'b010});
`ifdef RESULT_TX_PARITY_EN
      push_n({^w[8*b +: 8], 3'b010});
`endif
      push_n(4'b1010);
    end
    exp_q.push_back(4'b1101);
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_q.delete();
      exp_now <= IDLE_OBS;
    end else begin
      if (exp_now[2] && res_valid) push_word(res_data);
      if (exp_q.size() != 0) exp_now <= exp_q.pop_front();
      else                   exp_now <= IDLE_OBS;
    end
  end

  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;
  logic txlog[MAXC];
  logic dnlog[MAXC];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  // One clock: log and compare at negedge, return just after the next rising edge.
  task automatic tick();
    @(negedge clk);
    cyc++;
    if (cyc < MAXC) begin
      txlog[cyc] = tx;
      dnlog[cyc] = done;
    end
    if (!rst) check($sformatf("model@%0d", cyc), 32'({tx, res_ready, busy, done}), 32'(exp_now));
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(output int at);
    at = -1;
    for (int i = 0; i < WORD_CYC + 20 && at < 0; i++) begin
      tick();
      if (dnlog[cyc]) at = cyc;
    end
    check("done_seen", 32'(at >= 0), 32'd1);
  endtask

  task automatic start_word(input logic [31:0] w, output int acc);
    res_data  = w;
    res_valid = 1'b1;
    acc       = cyc + 1;
    tick();
    res_valid = 1'b0;
  endtask

  function automatic logic [7:0] dec_byte(input int s, input int k);
    logic [7:0] r;
    for (int j = 0; j < 8; j++) r[j] = txlog[s + k*FB*CPB + (1+j)*CPB + CPB/2];
    return r;
  endfunction

  function automatic logic [31:0] dec_word(input int s);
    logic [31:0] r;
    for (int k = 0; k < 4; k++) r[8*k +: 8] = dec_byte(s, k);
    return r;
  endfunction

  function automatic int count_done(input int a, input int b);
    int n = 0;
    for (int i = a; i <= b; i++) if (dnlog[i]) n++;
    return n;
  endfunction

  initial begin
    int          acc, acc1, d, d1, d2, hi, lows;
    logic [31:0] w;
    logic [9:0]  v;

    // Reset and idle
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset_state", 32'({tx, res_ready, busy, done}), 32'h0000000c);
    hi = 0;
    repeat (20) begin tick(); hi += int'(txlog[cyc]); end
    check("idle_tx_high", 32'(hi), 32'd20);

    // Single word 0x00000009
    start_word(32'h00000009, acc);
    check("ready_after_accept", 32'(res_ready), 32'd0);
    wait_done(d);
    check("single_done_latency", 32'(d - acc), 32'(DONE_LAT));
    for (int i = 0; i < 9; i++) v[i] = txlog[acc + 1 + i*CPB + CPB/2];
    v[9] = txlog[acc + 1 + (FB-1)*CPB + CPB/2];
    check("byte0_frame", 32'(v), 32'h00000212);
    w = dec_word(acc + 1);
    check("single_byte0", 32'(w[7:0]), 32'h09);
    check("single_upper", 32'(w[31:8]), 32'h0);
    repeat (10) tick();
    check("single_done_count", 32'(count_done(acc, cyc)), 32'd1);

    // Byte order
    start_word(32'hA55A0FF0, acc);
    wait_done(d);
    w = dec_word(acc + 1);
    check("order_b0", 32'(w[7:0]),   32'hF0);
    check("order_b1", 32'(w[15:8]),  32'h0F);
    check("order_b2", 32'(w[23:16]), 32'h5A);
    check("order_b3", 32'(w[31:24]), 32'hA5);
    repeat (5) tick();

    // Busy rejection
    start_word(32'h00000005, acc);
    repeat (4) tick();
    res_data  = 32'h00000010;
    res_valid = 1'b1;
    tick();
    res_valid = 1'b0;
    wait_done(d);
    check("reject_word", dec_word(acc + 1), 32'h00000005);
    lows = 0;
    repeat (12 * CPB) begin tick(); lows += int'(!txlog[cyc]); end
    check("reject_quiet", 32'(lows), 32'd0);
    check("reject_done_count", 32'(count_done(acc, cyc)), 32'd1);

    // Back-to-back
    res_data  = 32'h00000004;
    res_valid = 1'b1;
    acc1      = cyc + 1;
    tick();
    res_data  = 32'h00000008;
    wait_done(d1);
    res_valid = 1'b0;
    check("b2b_accepted_on_done", 32'(res_ready), 32'd0);
    check("b2b_start_no_gap", 32'(tx), 32'd0);
    wait_done(d2);
    check("b2b_second_latency", 32'(d2 - d1), 32'(DONE_LAT));
    check("b2b_word1", dec_word(acc1 + 1), 32'h00000004);
    check("b2b_word2", dec_word(d1 + 1), 32'h00000008);
    repeat (5) tick();

    // Mid-frame reset during byte 1
    start_word(32'h12345678, acc);
    repeat (FB * CPB + 10) tick();
    rst = 1'b1;
    #1;
    check("reset_async_tx", 32'(tx), 32'd1);
    check("reset_async_busy", 32'(busy), 32'd0);
    tick();
    tick();
    rst = 1'b0;
    check("reset_ready", 32'(res_ready), 32'd1);
    acc  = cyc;
    lows = 0;
    repeat (100) begin tick(); lows += int'(!txlog[cyc]); end
    check("reset_no_resume_tx", 32'(lows), 32'd0);
    check("reset_no_done", 32'(count_done(acc + 1, cyc)), 32'd0);

`ifdef RESULT_TX_PARITY_EN
    // Parity build: even parity per byte
    start_word(32'h00000007, acc);
    wait_done(d);
    check("parity_done_latency", 32'(d - acc), 32'd177);
    check("parity_b0", 32'(txlog[acc + 1 + 9*CPB + CPB/2]), 32'd1);
    check("parity_b123", 32'({txlog[acc + 1 + 1*FB*CPB + 9*CPB + CPB/2],
                              txlog[acc + 1 + 2*FB*CPB + 9*CPB + CPB/2],
                              txlog[acc + 1 + 3*FB*CPB + 9*CPB + CPB/2]}), 32'd0);
    check("parity_word", dec_word(acc + 1), 32'h00000007);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
